// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default geometry, the conv result RAM address map
// (also used by the conv write side) and the pooling FSM state type.
package cnn_pkg;

    localparam int DATA_W   = 16;
    localparam int FMAP_W   = 26;
    localparam int FMAP_H   = 26;
    localparam int NUM_FILT = 4;
    localparam int ADDR_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_FLUSH,
        ST_EMIT,
        ST_DONE
    } pool_state_t;

    // Feature maps are stored back-to-back, each one row-major.
    function automatic int unsigned conv_addr(
        input int unsigned f,
        input int unsigned row,
        input int unsigned col,
        input int unsigned fmap_w,
        input int unsigned fmap_h
    );
        return f * fmap_h * fmap_w + row * fmap_w + col;
    endfunction

endpackage

// File: rtl/pool_max_reducer.sv
// Combinational signed max of the running window max against the incoming
// RAM sample, plus the optional ReLU of that max.
//   run_max  : current running max of the window
//   sample   : newly returned RAM word
//   max_val  : signed max(run_max, sample)
//   relu_val : max_val, clamped to 0 when negative if RELU_EN != 0
module pool_max_reducer #(
    parameter int DATA_W  = 16,
    parameter int RELU_EN = 1
) (
    input  logic signed [DATA_W-1:0] run_max,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] max_val,
    output logic signed [DATA_W-1:0] relu_val
);

    always_comb begin
        max_val  = (sample > run_max) ? sample : run_max;
        // Sign-bit test instead of negation so the most negative value is safe.
        relu_val = ((RELU_EN != 0) && max_val[DATA_W-1]) ? '0 : max_val;
    end

endmodule

// File: rtl/maxpool_stream_unit.sv
// 2x2 stride-2 max-pool over every conv feature map held in the conv result
// RAM, streaming pooled values over valid/ready.
//   clk, rst_n            : clock, synchronous active-low reset
//   pool_start            : start pulse, honoured only in IDLE
//   pool_done             : one-cycle pulse after the final handshake
//   busy                  : high whenever not IDLE
//   rd_en/rd_addr/rd_data : RAM read port, data returns one cycle after rd_en
//   out_valid/out_ready   : output handshake
//   out_data/out_last     : pooled value, last flag on final value of final filter
module maxpool_stream_unit #(
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int FMAP_W   = cnn_pkg::FMAP_W,
    parameter int FMAP_H   = cnn_pkg::FMAP_H,
    parameter int NUM_FILT = cnn_pkg::NUM_FILT,
    parameter int RELU_EN  = 1,
    parameter int ADDR_W   = cnn_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pool_start,
    output logic                     pool_done,
    output logic                     busy,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    import cnn_pkg::*;

    localparam int OUT_W = FMAP_W / 2;
    localparam int OUT_H = FMAP_H / 2;

    pool_state_t state, state_next;

    logic [ADDR_W-1:0] f_cnt, row_cnt, col_cnt;
    logic [ADDR_W-1:0] addr_now, addr_hold;
    logic [1:0]        elem;
    logic              last_win, xfer;
    logic signed [DATA_W-1:0] run_max, max_val, relu_val;

    pool_max_reducer #(
        .DATA_W  (DATA_W),
        .RELU_EN (RELU_EN)
    ) u_reducer (
        .run_max  (run_max),
        .sample   (rd_data),
        .max_val  (max_val),
        .relu_val (relu_val)
    );

    assign last_win = (f_cnt == ADDR_W'(NUM_FILT - 1)) &&
                      (row_cnt == ADDR_W'(OUT_H - 1)) &&
                      (col_cnt == ADDR_W'(OUT_W - 1));
    assign xfer     = out_valid && out_ready;

    always_comb begin
        case (state)
            ST_RD1:  elem = 2'd1;
            ST_RD2:  elem = 2'd2;
            ST_RD3:  elem = 2'd3;
            default: elem = 2'd0;
        endcase
        // elem[1] selects the lower row of the window, elem[0] the right column.
        addr_now = ADDR_W'(conv_addr(32'(f_cnt),
                                     32'(row_cnt) * 2 + 32'(elem[1]),
                                     32'(col_cnt) * 2 + 32'(elem[0]),
                                     FMAP_W, FMAP_H));
        rd_addr  = rd_en ? addr_now : addr_hold;
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        pool_done  = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (pool_start) state_next = ST_RD0;
            ST_RD0:   begin rd_en = 1'b1; state_next = ST_RD1; end
            ST_RD1:   begin rd_en = 1'b1; state_next = ST_RD2; end
            ST_RD2:   begin rd_en = 1'b1; state_next = ST_RD3; end
            ST_RD3:   begin rd_en = 1'b1; state_next = ST_FLUSH; end
            ST_FLUSH: state_next = ST_EMIT;
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = last_win ? ST_DONE : ST_RD0;
            end
            ST_DONE: begin
                pool_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        out_last = out_valid && last_win;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_cnt     <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            addr_hold <= '0;
            run_max   <= '0;
            out_data  <= '0;
        end else begin
            if (rd_en) addr_hold <= addr_now;
            case (state)
                ST_IDLE: begin
                    f_cnt   <= '0;
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
                // Data lags the read by one cycle: element k arrives in RD(k+1).
                ST_RD1:          run_max  <= rd_data;
                ST_RD2, ST_RD3:  run_max  <= max_val;
                ST_FLUSH:        out_data <= relu_val;
                ST_EMIT: begin
                    if (xfer && !last_win) begin
                        if (col_cnt != ADDR_W'(OUT_W - 1)) begin
                            col_cnt <= col_cnt + ADDR_W'(1);
                        end else begin
                            col_cnt <= '0;
                            if (row_cnt != ADDR_W'(OUT_H - 1)) begin
                                row_cnt <= row_cnt + ADDR_W'(1);
                            end else begin
                                row_cnt <= '0;
                                f_cnt   <= f_cnt + ADDR_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream_unit.sv
module tb_maxpool_stream_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Instance A: 4x4, one filter, ReLU on
    logic start_a, ready_a, done_a, busy_a, rd_en_a, valid_a, last_a;
    logic [11:0] addr_a;
    logic signed [15:0] rdata_a, data_a;
    logic signed [15:0] mem_a [0:15];
    always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a[3:0]];

    maxpool_stream_unit #(.DATA_W(16), .FMAP_W(4), .FMAP_H(4), .NUM_FILT(1), .RELU_EN(1), .ADDR_W(12)) u_a (
        .clk(clk), .rst_n(rst_n), .pool_start(start_a), .pool_done(done_a), .busy(busy_a),
        .rd_en(rd_en_a), .rd_addr(addr_a), .rd_data(rdata_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_data(data_a), .out_last(last_a));

    // Instances P1/P0: 4 wide x 2 high, ReLU on / off, shared RAM contents
    logic start_p, done_p1, busy_p1, rd_en_p1, valid_p1, last_p1;
    logic done_p0, busy_p0, rd_en_p0, valid_p0, last_p0;
    logic [11:0] addr_p1, addr_p0;
    logic signed [15:0] rdata_p1, rdata_p0, data_p1, data_p0;
    logic signed [15:0] mem_p [0:7];
    always @(posedge clk) if (rd_en_p1) rdata_p1 <= mem_p[addr_p1[2:0]];
    always @(posedge clk) if (rd_en_p0) rdata_p0 <= mem_p[addr_p0[2:0]];

    maxpool_stream_unit #(.DATA_W(16), .FMAP_W(4), .FMAP_H(2), .NUM_FILT(1), .RELU_EN(1), .ADDR_W(12)) u_p1 (
        .clk(clk), .rst_n(rst_n), .pool_start(start_p), .pool_done(done_p1), .busy(busy_p1),
        .rd_en(rd_en_p1), .rd_addr(addr_p1), .rd_data(rdata_p1), .out_valid(valid_p1),
        .out_ready(1'b1), .out_data(data_p1), .out_last(last_p1));

    maxpool_stream_unit #(.DATA_W(16), .FMAP_W(4), .FMAP_H(2), .NUM_FILT(1), .RELU_EN(0), .ADDR_W(12)) u_p0 (
        .clk(clk), .rst_n(rst_n), .pool_start(start_p), .pool_done(done_p0), .busy(busy_p0),
        .rd_en(rd_en_p0), .rd_addr(addr_p0), .rd_data(rdata_p0), .out_valid(valid_p0),
        .out_ready(1'b1), .out_data(data_p0), .out_last(last_p0));

    // Instance C: 5x5, two filters, ReLU on
    logic start_c, done_c, busy_c, rd_en_c, valid_c, last_c;
    logic [11:0] addr_c;
    logic signed [15:0] rdata_c, data_c;
    logic signed [15:0] mem_c [0:63];
    always @(posedge clk) if (rd_en_c) rdata_c <= mem_c[addr_c[5:0]];

    maxpool_stream_unit #(.DATA_W(16), .FMAP_W(5), .FMAP_H(5), .NUM_FILT(2), .RELU_EN(1), .ADDR_W(12)) u_c (
        .clk(clk), .rst_n(rst_n), .pool_start(start_c), .pool_done(done_c), .busy(busy_c),
        .rd_en(rd_en_c), .rd_addr(addr_c), .rd_data(rdata_c), .out_valid(valid_c),
        .out_ready(1'b1), .out_data(data_c), .out_last(last_c));

    // Instance D: 6x6, four filters, ReLU off, random backpressure
    logic start_d, ready_d, done_d, busy_d, rd_en_d, valid_d, last_d;
    logic [11:0] addr_d;
    logic signed [15:0] rdata_d, data_d;
    logic signed [15:0] mem_d [0:255];
    always @(posedge clk) if (rd_en_d) rdata_d <= mem_d[addr_d[7:0]];

    maxpool_stream_unit #(.DATA_W(16), .FMAP_W(6), .FMAP_H(6), .NUM_FILT(4), .RELU_EN(0), .ADDR_W(12)) u_d (
        .clk(clk), .rst_n(rst_n), .pool_start(start_d), .pool_done(done_d), .busy(busy_d),
        .rd_en(rd_en_d), .rd_addr(addr_d), .rd_data(rdata_d), .out_valid(valid_d),
        .out_ready(ready_d), .out_data(data_d), .out_last(last_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; start_p = 0; start_c = 0; start_d = 0;
        ready_a = 1; ready_d = 1;
        tick(); tick();
        checks++; if (busy_a !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (rd_en_a !== 1'b0)   begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en_a); end
        checks++; if (addr_a !== 12'd0)   begin errors++; $display("FAIL reset_rd_addr got %0d want 0", addr_a); end
        checks++; if (valid_a !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (data_a !== 16'sd0)  begin errors++; $display("FAIL reset_data got %0d want 0", data_a); end
        checks++; if (last_a !== 1'b0)    begin errors++; $display("FAIL reset_last got %b want 0", last_a); end
        checks++; if (done_a !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        rst_n = 1'b1;
        tick();
    endtask

    // Full run on A with values 0..15; poke pulses pool_start mid-run.
    task automatic run_a(input string tag, input bit poke);
        int exp_v [4] = '{5, 7, 13, 15};
        int cyc, n, first_valid, last_cyc, done_cyc, done_cnt;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 1; n = 0; first_valid = 0; last_cyc = 0; done_cyc = 0; done_cnt = 0;
        checks++; if (rd_en_a !== 1'b1 || addr_a !== 12'd0) begin
            errors++; $display("FAIL %s_first_read got en=%b addr=%0d want en=1 addr=0", tag, rd_en_a, addr_a);
        end
        while (cyc <= 40) begin
            if (poke) start_a = (cyc == 8);
            if (valid_a && first_valid == 0) first_valid = cyc;
            if (valid_a && ready_a) begin
                if (n < 4) begin
                    checks++; if (data_a !== 16'(exp_v[n])) begin
                        errors++; $display("FAIL %s_data%0d got %0d want %0d", tag, n, data_a, exp_v[n]);
                    end
                end
                checks++; if (last_a !== (n == 3)) begin
                    errors++; $display("FAIL %s_last%0d got %b want %b", tag, n, last_a, (n == 3));
                end
                if (last_a) last_cyc = cyc;
                n++;
            end
            if (done_a) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
            tick();
            cyc++;
        end
        start_a = 1'b0;
        checks++; if (first_valid != 6) begin errors++; $display("FAIL %s_first_valid got %0d want 6", tag, first_valid); end
        checks++; if (n != 4)           begin errors++; $display("FAIL %s_count got %0d want 4", tag, n); end
        checks++; if (last_cyc != 24)   begin errors++; $display("FAIL %s_last_cycle got %0d want 24", tag, last_cyc); end
        checks++; if (done_cyc != 25)   begin errors++; $display("FAIL %s_done_cycle got %0d want 25", tag, done_cyc); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL %s_done_count got %0d want 1", tag, done_cnt); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL %s_idle_after got %b want 0", tag, busy_a); end
    endtask

    task automatic test_basic();
        run_a("basic", 1'b0);
    endtask

    task automatic test_relu();
        logic signed [15:0] got1 [2];
        logic signed [15:0] got0 [2];
        int n1 = 0, n0 = 0;
        mem_p[0] = -16'sd3; mem_p[1] = -16'sd8; mem_p[4] = -16'sd1; mem_p[5] = -16'sd5;
        mem_p[2] = 16'sh8000; mem_p[3] = 16'sh8000; mem_p[6] = 16'sh8000; mem_p[7] = 16'sh8000;
        start_p = 1'b1;
        tick();
        start_p = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (valid_p1) begin if (n1 < 2) got1[n1] = data_p1; n1++; end
            if (valid_p0) begin if (n0 < 2) got0[n0] = data_p0; n0++; end
            tick();
        end
        checks++; if (n1 != 2) begin errors++; $display("FAIL relu_on_count got %0d want 2", n1); end
        checks++; if (n0 != 2) begin errors++; $display("FAIL relu_off_count got %0d want 2", n0); end
        if (n1 >= 2) begin
            checks++; if (got1[0] !== 16'sd0) begin errors++; $display("FAIL relu_on_neg got %0d want 0", got1[0]); end
            checks++; if (got1[1] !== 16'sd0) begin errors++; $display("FAIL relu_on_min got %0d want 0", got1[1]); end
        end
        if (n0 >= 2) begin
            checks++; if (got0[0] !== -16'sd1) begin errors++; $display("FAIL relu_off_neg got %0d want -1", got0[0]); end
            checks++; if (got0[1] !== 16'sh8000) begin errors++; $display("FAIL relu_off_min got %0d want -32768", got0[1]); end
        end
    endtask

    task automatic test_back_pressure();
        int k;
        logic signed [15:0] held;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!valid_a && k < 20) begin tick(); k++; end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_wait_valid got %b want 1", valid_a); end
        held = data_a;
        checks++; if (held !== 16'sd5) begin errors++; $display("FAIL bp_first_data got %0d want 5", held); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (valid_a !== 1'b1 || data_a !== held || rd_en_a !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%0d en=%b want v=1 d=%0d en=0", i, valid_a, data_a, rd_en_a, held);
            end
        end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        checks++; if (valid_a !== 1'b0 || rd_en_a !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b en=%b want v=0 en=1", valid_a, rd_en_a);
        end
        k = 0;
        while (!valid_a && k < 20) begin tick(); k++; end
        checks++; if (valid_a !== 1'b1 || data_a !== 16'sd7) begin
            errors++; $display("FAIL bp_second got v=%b d=%0d want v=1 d=7", valid_a, data_a);
        end
        ready_a = 1'b1;
        k = 0;
        while (!done_a && k < 40) begin tick(); k++; end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL bp_drain_done got %b want 1", done_a); end
        tick();
    endtask

    task automatic test_odd_dims();
        int exp_v [8] = '{6, 8, 16, 18, 31, 33, 41, 43};
        int n = 0, bad = 0, first_f1 = -1, done_seen = 0;
        int a, r, c;
        for (int i = 0; i < 64; i++) mem_c[i] = 16'(i % 25);
        for (int i = 25; i < 50; i++) mem_c[i] = 16'(i);
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int cyc = 0; cyc < 100 && done_seen == 0; cyc++) begin
            if (rd_en_c) begin
                a = int'(addr_c);
                r = (a % 25) / 5;
                c = a % 5;
                if (a >= 50 || r == 4 || c == 4) bad++;
                if (a >= 25 && first_f1 < 0) first_f1 = a;
            end
            if (valid_c) begin
                if (n < 8) begin
                    checks++; if (data_c !== 16'(exp_v[n])) begin
                        errors++; $display("FAIL odd_data%0d got %0d want %0d", n, data_c, exp_v[n]);
                    end
                end
                n++;
            end
            if (done_c) done_seen = 1;
            tick();
        end
        checks++; if (n != 8)         begin errors++; $display("FAIL odd_count got %0d want 8", n); end
        checks++; if (bad != 0)       begin errors++; $display("FAIL odd_edge_reads got %0d want 0", bad); end
        checks++; if (first_f1 != 25) begin errors++; $display("FAIL odd_f1_base got %0d want 25", first_f1); end
        checks++; if (done_seen != 1) begin errors++; $display("FAIL odd_done got %0d want 1", done_seen); end
    endtask

    task automatic test_mid_start_and_reset();
        int k, dn;
        run_a("mid_start", 1'b1);
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!valid_a && k < 20) begin tick(); k++; end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL rst_reach_emit got %b want 1", valid_a); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({busy_a, rd_en_a, valid_a, last_a, done_a} !== 5'b0 || addr_a !== 12'd0 || data_a !== 16'sd0) begin
            errors++; $display("FAIL rst_outputs got b=%b e=%b a=%0d v=%b d=%0d l=%b p=%b want all 0",
                               busy_a, rd_en_a, addr_a, valid_a, data_a, last_a, done_a);
        end
        ready_a = 1'b1;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a || busy_a || rd_en_a) dn++;
            tick();
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL rst_silent got %0d active cycles want 0", dn); end
        run_a("after_reset", 1'b0);
    endtask

    task automatic test_random();
        logic signed [15:0] exp_q [$];
        logic signed [15:0] m, v;
        int n = 0, done_seen = 0, pv = 0, pr = 0;
        for (int i = 0; i < 256; i++) mem_d[i] = 16'($urandom);
        mem_d[7] = 16'sh8000;
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    m = mem_d[f * 36 + (2 * r) * 6 + 2 * c];
                    v = mem_d[f * 36 + (2 * r) * 6 + 2 * c + 1]; if (v > m) m = v;
                    v = mem_d[f * 36 + (2 * r + 1) * 6 + 2 * c]; if (v > m) m = v;
                    v = mem_d[f * 36 + (2 * r + 1) * 6 + 2 * c + 1]; if (v > m) m = v;
                    exp_q.push_back(m);
                end
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int cyc = 0; cyc < 3000 && done_seen == 0; cyc++) begin
            ready_d = 1'($urandom_range(0, 1));
            if (pv != 0 && pr == 0 && !valid_d) begin
                checks++; errors++; $display("FAIL rand_valid_drop at cycle %0d got 0 want 1", cyc);
            end
            if (valid_d && ready_d) begin
                if (n < 36) begin
                    checks++; if (data_d !== exp_q[n]) begin
                        errors++; $display("FAIL rand_data%0d got %0d want %0d", n, data_d, exp_q[n]);
                    end
                end
                checks++; if (last_d !== (n == 35)) begin
                    errors++; $display("FAIL rand_last%0d got %b want %b", n, last_d, (n == 35));
                end
                n++;
            end
            pv = int'(valid_d); pr = int'(ready_d);
            if (done_d) done_seen = 1;
            tick();
        end
        ready_d = 1'b1;
        checks++; if (n != 36)        begin errors++; $display("FAIL rand_count got %0d want 36", n); end
        checks++; if (done_seen != 1) begin errors++; $display("FAIL rand_done got %0d want 1", done_seen); end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_back_pressure();
        test_odd_dims();
        test_mid_start_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
